// File: rtl/filtro_secuenciador.sv
// Sample-rate sequencer for the HP/LP filter cascade: ADC handshake in, one-cycle
// cascade Enable, fixed-latency settle, DAC handshake out, plus drop and transfer counters.
module filtro_secuenciador #(
  parameter int W   = 25,
  parameter int LAT = 2
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                Run,
  input  logic                clr_status,
  input  logic                adc_valid,
  input  logic signed [W-1:0] adc_data,
  output logic                adc_ready,
  output logic                Enable,
  output logic signed [W-1:0] u_filt,
  input  logic signed [W-1:0] y_filt,
  output logic                dac_valid,
  output logic signed [W-1:0] dac_data,
  input  logic                dac_ready,
  output logic                busy,
  output logic                overrun,
  output logic [7:0]          drop_cnt,
  output logic [15:0]         sample_cnt
);

  typedef enum logic [2:0] {IDLE, ACQ, STEP, SETTLE, OUT} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(LAT - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] settle_cnt;
  logic       accept;
  logic       capture;
  logic       transfer;
  logic       drop;

  // NOTE: every signal written in this block is given a default first, so no
  // branch leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    transfer   = 1'b0;
    case (state)
      IDLE: begin
        if (Run) state_next = ACQ;
      end
      ACQ: begin
        if (adc_valid) begin
          accept     = 1'b1;
          state_next = STEP;
        end else if (!Run) begin
          state_next = IDLE;
        end
      end
      STEP: begin
        state_next = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == 4'd0) begin
          capture    = 1'b1;
          state_next = OUT;
        end
      end
      OUT: begin
        if (dac_ready) begin
          transfer   = 1'b1;
          state_next = Run ? ACQ : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A sample offered while we cannot take it counts as lost only while running.
  assign drop = adc_valid && !adc_ready && Run;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values and they all update together.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      settle_cnt <= 4'd0;
      adc_ready  <= 1'b0;
      Enable     <= 1'b0;
      dac_valid  <= 1'b0;
      busy       <= 1'b0;
      u_filt     <= '0;
      dac_data   <= '0;
      overrun    <= 1'b0;
      drop_cnt   <= 8'd0;
      sample_cnt <= 16'd0;
    end else begin
      state <= state_next;

      // Strobes are registered decodes of the next state, so they track the state flop exactly.
      adc_ready <= (state_next == ACQ);
      Enable    <= (state_next == STEP);
      dac_valid <= (state_next == OUT);
      busy      <= (state_next != IDLE);

      if (state == STEP) begin
        settle_cnt <= SETTLE_LOAD;
      end else if (state == SETTLE && settle_cnt != 4'd0) begin
        settle_cnt <= settle_cnt - 4'd1;
      end

      if (accept)   u_filt     <= adc_data;
      if (capture)  dac_data   <= y_filt;
      if (transfer) sample_cnt <= sample_cnt + 16'd1;

      // A drop on the same edge as a clear wins: the clear zeroes, the drop then counts one.
      if (drop) begin
        overrun <= 1'b1;
        if (clr_status)             drop_cnt <= 8'd1;
        else if (drop_cnt != 8'd255) drop_cnt <= drop_cnt + 8'd1;
      end else if (clr_status) begin
        overrun  <= 1'b0;
        drop_cnt <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_filtro_secuenciador.sv
// Bench for filtro_secuenciador: two instances (LAT=2 and LAT=4) each driving a small
// cascade model; a scoreboard queue per instance is checked on every DAC transfer.
module tb_filtro_secuenciador;

  localparam int          W     = 25;
  localparam int          LAT_A = 2;
  localparam int          LAT_B = 4;
  localparam logic [W-1:0] JUNK = 25'h1C0FFEE;

  typedef struct {
    logic [W-1:0] d;
    logic [W-1:0] e;
  } vec_t;

  // Cascade model output is the bitwise complement of its input; expectations are hand-computed.
  vec_t vecs [4] = '{
    '{25'h0FFFFFF, 25'h1000000},
    '{25'h1FFFFFF, 25'h0000000},
    '{25'h0000001, 25'h1FFFFFE},
    '{25'h1555555, 25'h0AAAAAA}
  };

  logic         CLK;
  logic         rst  [2];
  logic         run  [2];
  logic         clr  [2];
  logic         av   [2];
  logic         ar   [2];
  logic         en   [2];
  logic         dv   [2];
  logic         dr   [2];
  logic         busy [2];
  logic         ovr  [2];
  logic [W-1:0] ad   [2];
  logic [W-1:0] uf   [2];
  logic [W-1:0] yf   [2];
  logic [W-1:0] dd   [2];
  logic [7:0]   dc   [2];
  logic [15:0]  sc   [2];

  logic [W-1:0] pa [LAT_A];
  logic [W-1:0] pb [LAT_B];
  logic [W-1:0] qa [$];
  logic [W-1:0] qb [$];

  int checks = 0;
  int errors = 0;

  filtro_secuenciador #(.W(W), .LAT(LAT_A)) dut_a (
    .CLK(CLK), .Reset(rst[0]), .Run(run[0]), .clr_status(clr[0]),
    .adc_valid(av[0]), .adc_data(ad[0]), .adc_ready(ar[0]),
    .Enable(en[0]), .u_filt(uf[0]), .y_filt(yf[0]),
    .dac_valid(dv[0]), .dac_data(dd[0]), .dac_ready(dr[0]),
    .busy(busy[0]), .overrun(ovr[0]), .drop_cnt(dc[0]), .sample_cnt(sc[0])
  );

  filtro_secuenciador #(.W(W), .LAT(LAT_B)) dut_b (
    .CLK(CLK), .Reset(rst[1]), .Run(run[1]), .clr_status(clr[1]),
    .adc_valid(av[1]), .adc_data(ad[1]), .adc_ready(ar[1]),
    .Enable(en[1]), .u_filt(uf[1]), .y_filt(yf[1]),
    .dac_valid(dv[1]), .dac_data(dd[1]), .dac_ready(dr[1]),
    .busy(busy[1]), .overrun(ovr[1]), .drop_cnt(dc[1]), .sample_cnt(sc[1])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Cascade model: result is only correct exactly LAT cycles after the Enable pulse.
  always @(posedge CLK) begin
    pa[0] <= en[0] ? ~uf[0] : JUNK;
    pa[1] <= pa[0];
    pb[0] <= en[1] ? ~uf[1] : JUNK;
    for (int k = 1; k < LAT_B; k++) pb[k] <= pb[k-1];
  end
  assign yf[0] = pa[LAT_A-1];
  assign yf[1] = pb[LAT_B-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic score(input int i);
    logic [W-1:0] exp_v;
    bit           have;
    have  = 1'b0;
    exp_v = '0;
    if (i == 0 && qa.size() > 0) begin
      exp_v = qa.pop_front();
      have  = 1'b1;
    end else if (i == 1 && qb.size() > 0) begin
      exp_v = qb.pop_front();
      have  = 1'b1;
    end
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL dac_xfer[%0d]: got %h expected no transfer", i, dd[i]);
    end else if (dd[i] !== exp_v) begin
      errors++;
      $display("FAIL dac_xfer[%0d]: got %h expected %h", i, dd[i], exp_v);
    end
  endtask

  // Monitor: a transfer happens on the next rising edge whenever valid and ready are both high.
  always @(negedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst[i] && dv[i] && dr[i]) score(i);
    end
  end

  task automatic check_zero(input int i);
    check("zero_adc_ready",  32'(ar[i]),   0);
    check("zero_enable",     32'(en[i]),   0);
    check("zero_u_filt",     32'(uf[i]),   0);
    check("zero_dac_valid",  32'(dv[i]),   0);
    check("zero_dac_data",   32'(dd[i]),   0);
    check("zero_busy",       32'(busy[i]), 0);
    check("zero_overrun",    32'(ovr[i]),  0);
    check("zero_drop_cnt",   32'(dc[i]),   0);
    check("zero_sample_cnt", 32'(sc[i]),   0);
  endtask

  // Offer one sample, push its expected result at the accept edge, return once dac_valid is up.
  task automatic send(input int i, input logic [W-1:0] d, input logic [W-1:0] e, input int lat);
    int n;
    int en_n;
    ad[i] = d;
    av[i] = 1'b1;
    n = 0;
    while (!ar[i] && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("adc_ready_before_accept", 32'(ar[i]), 1);
    @(posedge CLK);
    if (i == 0) qa.push_back(e);
    else        qb.push_back(e);
    #1 av[i] = 1'b0;
    n    = 0;
    en_n = 0;
    while (!dv[i] && n < 40) begin
      @(negedge CLK);
      n++;
      if (en[i]) en_n++;
    end
    check("enable_pulse_count", 32'(en_n), 1);
    check("dac_valid_latency", 32'(n - 1), 32'(lat + 1));
    check("u_filt_value", 32'(uf[i]), 32'(d));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      run[i] = 1'b0;
      clr[i] = 1'b0;
      av[i]  = 1'b0;
      ad[i]  = '0;
      dr[i]  = 1'b1;
    end
    repeat (3) @(negedge CLK);
    check_zero(0);

    // First sample straight out of reset, adc_valid already held
    @(posedge CLK); #1;
    rst[0] = 1'b0;
    run[0] = 1'b1;
    ad[0]  = 25'h0000123;
    av[0]  = 1'b1;
    @(negedge CLK);
    check("ready_low_in_idle", 32'(ar[0]), 0);
    @(negedge CLK);
    check("ready_after_release", 32'(ar[0]), 1);
    check("idle_run_drop_cnt", 32'(dc[0]), 1);
    check("idle_run_overrun", 32'(ovr[0]), 1);
    send(0, 25'h0000123, 25'h1FFFEDC, LAT_A);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("ready_after_transfer", 32'(ar[0]), 1);
    check("sample_cnt_first", 32'(sc[0]), 1);

    foreach (vecs[v]) begin
      send(0, vecs[v].d, vecs[v].e, LAT_A);
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    check("sample_cnt_after_table", 32'(sc[0]), 5);

    @(posedge CLK); #1 clr[0] = 1'b1;
    @(posedge CLK); #1 clr[0] = 1'b0;
    @(negedge CLK);
    check("clr_drop_cnt", 32'(dc[0]), 0);
    check("clr_overrun", 32'(ovr[0]), 0);

    // DAC backpressure for 10 cycles with a new sample held on the ADC side
    @(posedge CLK); #1 dr[0] = 1'b0;
    send(0, 25'h1000000, 25'h0FFFFFF, LAT_A);
    ad[0] = 25'h0000055;
    av[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      check("stall_dac_valid", 32'(dv[0]), 1);
      check("stall_dac_data", 32'(dd[0]), 32'(25'h0FFFFFF));
      check("stall_adc_ready", 32'(ar[0]), 0);
      check("stall_drop_cnt", 32'(dc[0]), 32'(k));
    end
    check("stall_overrun", 32'(ovr[0]), 1);
    av[0] = 1'b0;
    @(posedge CLK); #1 dr[0] = 1'b1;
    @(posedge CLK); #1;

    // Drop counter saturation, clear, and clear coincident with a drop
    dr[0] = 1'b0;
    send(0, 25'h0AAAAAA, 25'h1555555, LAT_A);
    av[0] = 1'b1;
    repeat (300) @(negedge CLK);
    check("sat_drop_cnt", 32'(dc[0]), 255);
    check("sat_overrun", 32'(ovr[0]), 1);
    @(posedge CLK); #1;
    av[0]  = 1'b0;
    clr[0] = 1'b1;
    @(posedge CLK); #1 clr[0] = 1'b0;
    @(negedge CLK);
    check("sat_clr_drop_cnt", 32'(dc[0]), 0);
    check("sat_clr_overrun", 32'(ovr[0]), 0);
    @(posedge CLK); #1;
    av[0]  = 1'b1;
    clr[0] = 1'b1;
    @(posedge CLK); #1;
    av[0]  = 1'b0;
    clr[0] = 1'b0;
    @(negedge CLK);
    check("clr_with_drop_cnt", 32'(dc[0]), 1);
    check("clr_with_drop_overrun", 32'(ovr[0]), 1);
    @(posedge CLK); #1 dr[0] = 1'b1;
    @(posedge CLK); #1;

    // Run falls while the sample is settling: it still completes and transfers
    ad[0] = 25'h1234567;
    av[0] = 1'b1;
    @(posedge CLK);
    qa.push_back(25'h0DCBA98);
    #1 av[0] = 1'b0;
    @(posedge CLK); #1 run[0] = 1'b0;
    n = 0;
    while (busy[0] && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check("stop_busy", 32'(busy[0]), 0);
    check("stop_dac_valid", 32'(dv[0]), 0);
    check("stop_sample_cnt", 32'(sc[0]), 8);
    av[0] = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      check("stop_no_adc_ready", 32'(ar[0]), 0);
    end
    check("stop_idle_no_drop", 32'(dc[0]), 1);
    av[0] = 1'b0;

    // Transfer counter wrap from 0xFFFF
    force dut_a.sample_cnt = 16'hFFFF;
    @(negedge CLK);
    release dut_a.sample_cnt;
    check("preload_sample_cnt", 32'(sc[0]), 32'h0000FFFF);
    @(posedge CLK); #1 run[0] = 1'b1;
    @(posedge CLK); #1;
    send(0, 25'h0F0F0F0, 25'h10F0F0F, LAT_A);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("wrap_sample_cnt", 32'(sc[0]), 0);

    // LAT=4 instance: one sample, then asynchronous reset in SETTLE, then recovery
    @(posedge CLK); #1;
    rst[1] = 1'b0;
    run[1] = 1'b1;
    @(posedge CLK); #1;
    send(1, 25'h0FFFFFF, 25'h1000000, LAT_B);
    @(posedge CLK); #1;
    ad[1] = 25'h0123456;
    av[1] = 1'b1;
    @(posedge CLK);
    #1 av[1] = 1'b0;
    @(posedge CLK);
    #2 rst[1] = 1'b1;
    #1 check_zero(1);
    @(posedge CLK); #1 rst[1] = 1'b0;
    @(posedge CLK); #1;
    send(1, 25'h1ABCDEF, 25'h0543210, LAT_B);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("recover_sample_cnt", 32'(sc[1]), 1);

    check("queue_a_drained", 32'(qa.size()), 0);
    check("queue_b_drained", 32'(qb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/filtro_secuenciador.md
# filtro_secuenciador

Sample-rate sequencer for the high-pass/low-pass filter cascade. Accepts one ADC sample at a time through a valid/ready handshake and presents it on the cascade input. Pulses the cascade `Enable` for exactly one cycle, waits the cascade's fixed latency, then captures the cascade output and hands it to the DAC through a valid/ready handshake. Sits between the ADC interface, the filter cascade and the DAC interface, and shares `CLK`/`Reset` with the cascade.

## Interface
- `W`, 25, sample width (signed, two's complement)
- `LAT`, 2, cycles from `Enable` pulse to valid cascade output; legal range 1..15
- `CLK`  in  1  system clock, rising edge
- `Reset`  in  1  asynchronous, active-high reset
- `Run`  in  1  level; 1 = process samples, 0 = stop after current sample
- `clr_status`  in  1  one-cycle pulse; clears `overrun` and `drop_cnt`
- `adc_valid`  in  1  ADC sample available
- `adc_data`  in  W  signed ADC sample
- `adc_ready`  out  1  sequencer accepts a sample this cycle
- `Enable`  out  1  cascade enable strobe, one cycle per sample
- `u_filt`  out  W  signed cascade input
- `y_filt`  in  W  signed cascade output
- `dac_valid`  out  1  filtered sample available
- `dac_data`  out  W  signed filtered sample
- `dac_ready`  in  1  DAC accepts sample
- `busy`  out  1  state not IDLE
- `overrun`  out  1  sticky; a sample was offered while `adc_ready`=0
- `drop_cnt`  out  8  dropped samples, saturating at 255
- `sample_cnt`  out  16  completed DAC transfers, wraps 0xFFFF->0

## Operation
- FSM states and transitions:
  - IDLE -> ACQ when `Run`=1.
  - ACQ -> STEP on `adc_valid`&`adc_ready`. `u_filt` <= `adc_data`.
  - ACQ -> IDLE when `Run`=0 and no accept.
  - STEP -> SETTLE unconditionally. STEP is 1 cycle with `Enable`=1.
  - SETTLE lasts exactly `LAT` cycles, with a down-counter loaded with `LAT`-1. On the last SETTLE edge: `dac_data` <= `y_filt`, state -> OUT.
  - OUT holds `dac_valid`=1 until `dac_ready`=1 is sampled. On transfer: `sample_cnt`+1, then ACQ if `Run`=1, else IDLE.
- `adc_ready`=1 only in ACQ. `Enable`=1 only in STEP. `dac_valid`=1 only in OUT.
- `u_filt` holds its value from accept until the next accept. `dac_data` stays stable throughout OUT.
- `Run` falling mid-sample: the sample in flight completes, including the DAC transfer, before the FSM reaches IDLE. No sample is ever abandoned except by `Reset`.
- Drop rule: a cycle with `adc_valid`=1 and `adc_ready`=0 while `Run`=1 is a drop.
  - Each such edge sets `overrun` and increments `drop_cnt`, saturating at 255.
  - A held `adc_valid` counts once per cycle.
  - In IDLE with `Run`=0, samples are ignored and are not drops.
- `clr_status` and a drop on the same edge: the drop wins. Result is `overrun`=1, `drop_cnt`=1.
- No arithmetic on the sample path. Data passes bit-exact, signed W bits.

## Timing
- Reset (asynchronous): state IDLE. All outputs 0: `adc_ready`, `Enable`, `u_filt`, `dac_valid`, `dac_data`, `busy`, `overrun`, `drop_cnt`, `sample_cnt`.
- Reset mid-operation aborts immediately. The cascade is reset by the same `Reset`, so no partial `Enable` survives.
- Accept on edge E0:
  - `Enable` is high between E0 and E1.
  - `dac_valid` rises after edge E(1+`LAT`).
  - With `dac_ready` already high, the transfer happens at E(2+`LAT`), and `adc_ready` is high again after it.
- Throughput: one sample per `LAT`+3 cycles with zero backpressure. This is 5 cycles at `LAT`=2.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset then `Run`=1, `adc_data`=0x0000123 with `adc_valid` held -> `adc_ready` high 1 cycle after reset release. `Enable` single-cycle pulse. `u_filt`=0x0000123. `dac_valid` rises exactly `LAT`+1 edges after the accept. `dac_data` equals the `y_filt` model value.
- `dac_ready`=0 for 10 cycles during OUT -> `dac_valid` and `dac_data` are stable for all 10 cycles. `adc_ready`=0 throughout. Each held `adc_valid` cycle increments `drop_cnt`. `overrun`=1.
- 300 consecutive drops -> `drop_cnt` saturates at 255. Then a `clr_status` pulse -> `overrun`=0, `drop_cnt`=0. `clr_status` coincident with a drop -> `drop_cnt`=1, `overrun`=1.
- Deassert `Run` in SETTLE -> the sample completes and the DAC transfer occurs. Then IDLE with `busy`=0, and no further `adc_ready`.
- Preload 0xFFFF transfers, then run one more sample -> `sample_cnt` wraps to 0x0000.
- Assert `Reset` during SETTLE with `LAT`=4 -> all outputs 0 immediately, with no clock needed. After release with `Run`=1, the next sample processes normally.
